// File: rtl/vga_pkg.sv
// Shared geometry, timing constants and fetch FSM encoding for the VGA
// framebuffer scheduler slice.
package vga_pkg;

  localparam int unsigned HMAX            = 800;
  localparam int unsigned VMAX            = 525;
  localparam int unsigned HLINES          = 640;
  localparam int unsigned VLINES          = 480;
  localparam int unsigned FB_W            = 160;
  localparam int unsigned FB_H            = 120;
  localparam int unsigned SCALE           = 4;
  localparam int unsigned PIX_W           = 12;
  localparam int unsigned ADDR_W          = 15;
  localparam int unsigned FETCH_START_DEF = 600;
  localparam int unsigned COL_W           = $clog2(FB_W);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: the fetch side fills the bank not selected by
// bank_sel while the display side reads the selected bank asynchronously.
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic             pixel_clk,
  input  logic             bank_sel,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [COL_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] bank0 [FB_W];
  logic [PIX_W-1:0] bank1 [FB_W];

  always_ff @(posedge pixel_clk) begin
    if (we) begin
      if (bank_sel) bank0[waddr] <= wdata;
      else          bank1[waddr] <= wdata;
    end
  end

  assign rdata = bank_sel ? bank1[raddr] : bank0[raddr];

endmodule

// File: rtl/vga_fb_scheduler.sv
// Framebuffer port arbiter: deadline-bound row prefetch for the display
// has priority over the low-priority game-logic writer.
module vga_fb_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned FETCH_START = FETCH_START_DEF
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [10:0]       hcounter,
  input  logic [10:0]       vcounter,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              fetch_err
);

  localparam int unsigned       SH      = $clog2(SCALE);
  localparam int unsigned       CNT_W   = $clog2(FB_W + 1);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

  fetch_state_t      state, state_nx;
  logic [10:0]       nv;
  logic              trigger, at_hmax, visible, wr_ok, lb_we;
  logic [ADDR_W-1:0] nv_base, row_base;
  logic [CNT_W-1:0]  issue_col;
  logic              rd_v0, rd_v1;
  logic [COL_W-1:0]  rd_col0, rd_col1, lb_raddr;
  logic              bank_sel, bank_valid;
  logic [PIX_W-1:0]  lb_rdata;

  assign nv      = (vcounter == 11'(VMAX)) ? '0 : vcounter + 11'd1;
  assign trigger = (hcounter == 11'(FETCH_START)) && (nv < 11'(VLINES)) &&
                   ((nv & 11'(SCALE - 1)) == '0);
  assign nv_base = ADDR_W'(nv >> SH) * ADDR_W'(FB_W);
  assign at_hmax = (hcounter == 11'(HMAX));
  assign lb_we   = rd_v1 && (state == FETCH);
  assign wr_ok   = (state != FETCH) && !trigger && wr_req && !wr_gnt;
  assign visible = (hcounter < 11'(HLINES)) && (vcounter < 11'(VLINES));
  assign lb_raddr = visible ? hcounter[SH +: COL_W] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trigger) state_nx = FETCH;
      FETCH: begin
        if (at_hmax) state_nx = IDLE;
        else if (lb_we && rd_col1 == COL_W'(FB_W - 1)) state_nx = DONE;
      end
      DONE:    if (at_hmax) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state      <= IDLE;
      bank_sel   <= 1'b0;
      bank_valid <= 1'b0;
      fetch_err  <= 1'b0;
      issue_col  <= '0;
      row_base   <= '0;
      rd_v0      <= 1'b0;
      rd_v1      <= 1'b0;
      rd_col0    <= '0;
      rd_col1    <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_gnt     <= 1'b0;
      pix_data   <= '0;
    end else begin
      state   <= state_nx;
      mem_we  <= 1'b0;
      wr_gnt  <= 1'b0;
      rd_v0   <= 1'b0;
      // read data lands one cycle behind its address; an abort kills it in flight
      rd_v1   <= rd_v0 && (state_nx == FETCH);
      rd_col1 <= rd_col0;

      if (state == IDLE && trigger) begin
        row_base  <= nv_base;
        mem_addr  <= nv_base;
        issue_col <= CNT_W'(1);
        rd_v0     <= 1'b1;
        rd_col0   <= '0;
      end else if (state == FETCH && !at_hmax && issue_col < CNT_W'(FB_W)) begin
        mem_addr  <= row_base + ADDR_W'(issue_col);
        issue_col <= issue_col + CNT_W'(1);
        rd_v0     <= 1'b1;
        rd_col0   <= COL_W'(issue_col);
      end else if (wr_ok) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        mem_we    <= (wr_addr < FB_SIZE);
        wr_gnt    <= 1'b1;
      end

      if (state == FETCH && at_hmax) fetch_err <= 1'b1;
      if (state == DONE && at_hmax) begin
        bank_sel   <= ~bank_sel;
        bank_valid <= 1'b1;
      end

      pix_data <= (visible && bank_valid) ? lb_rdata : '0;
    end
  end

  vga_line_buffer u_line_buffer (
    .pixel_clk (pixel_clk),
    .bank_sel  (bank_sel),
    .we        (lb_we),
    .waddr     (rd_col1),
    .wdata     (mem_rdata),
    .raddr     (lb_raddr),
    .rdata     (lb_rdata)
  );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: row prefetch, pixel streaming,
// writer arbitration, dropped writes, reset abort and fetch deadline.
module tb_vga_fb_scheduler;
  import vga_pkg::*;

  logic              pixel_clk = 1'b0;
  logic              rst;
  logic [10:0]       hcounter, vcounter;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_gnt, mem_we, fetch_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata, mem_rdata, pix_data;

  logic              wr_gnt2, mem_we2, fetch_err2;
  logic [ADDR_W-1:0] mem_addr2;
  logic [PIX_W-1:0]  mem_wdata2, pix_data2;
  logic              zero_bit  = 1'b0;
  logic [ADDR_W-1:0] zero_addr = '0;
  logic [PIX_W-1:0]  zero_pix  = '0;

  logic [PIX_W-1:0]  fbmem    [FB_W*FB_H];
  logic [PIX_W-1:0]  row0_exp [FB_W];
  int vectors = 0;
  int miscompares = 0;

  always #5 pixel_clk = ~pixel_clk;

  // single-port BRAM model with one-cycle read latency
  always @(posedge pixel_clk) begin
    if (mem_we) fbmem[mem_addr] <= mem_wdata;
    mem_rdata <= fbmem[mem_addr];
  end

  vga_fb_scheduler dut (
    .pixel_clk (pixel_clk), .rst (rst), .hcounter (hcounter), .vcounter (vcounter),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_gnt (wr_gnt),
    .mem_addr (mem_addr), .mem_we (mem_we), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .pix_data (pix_data), .fetch_err (fetch_err)
  );

  vga_fb_scheduler #(.FETCH_START(700)) dut_late (
    .pixel_clk (pixel_clk), .rst (rst), .hcounter (hcounter), .vcounter (vcounter),
    .wr_req (zero_bit), .wr_addr (zero_addr), .wr_data (zero_pix), .wr_gnt (wr_gnt2),
    .mem_addr (mem_addr2), .mem_we (mem_we2), .mem_wdata (mem_wdata2),
    .mem_rdata (zero_pix), .pix_data (pix_data2), .fetch_err (fetch_err2)
  );

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge, so they show the values present during cycle h.
  task automatic cyc(input int h, input int v, input logic req, input logic rs);
    @(posedge pixel_clk);
    #1;
    hcounter = 11'(h);
    vcounter = 11'(v);
    wr_req   = req;
    rst      = rs;
    @(negedge pixel_clk);
  endtask

  task automatic test_reset();
    cyc(0, 0, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1);
    vectors++; if (wr_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_wr_gnt: got %b want 0", wr_gnt); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    vectors++; if (pix_data !== '0) begin miscompares++; $display("FAIL reset_pix_data: got %h want 0", pix_data); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_row_fetch();
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, 3, 1'b0, 1'b0);
      if (h >= 601 && h <= 760) begin
        vectors++;
        if (mem_addr !== ADDR_W'(160 + h - 601) || mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL row1_fetch_addr h=%0d: got addr=%0d we=%b want addr=%0d we=0", h, mem_addr, mem_we, 160 + h - 601);
        end
      end
    end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL row1_fetch_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_pixel_stream();
    logic [PIX_W-1:0] exp;
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, 4, 1'b0, 1'b0);
      exp = (h >= 1 && h <= 640) ? PIX_W'((h - 1) / 4) : '0;
      vectors++;
      if (pix_data !== exp) begin
        miscompares++;
        $display("FAIL row1_pix h=%0d: got %h want %h", h, pix_data, exp);
      end
    end
  endtask

  task automatic test_write_during_fetch();
    wr_addr = ADDR_W'(100);
    wr_data = 12'hABC;
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, 7, (h >= 600 && h <= 763), 1'b0);
      if (h >= 600 && h <= 762) begin
        vectors++;
        if (wr_gnt !== 1'b0 || mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL wr_blocked h=%0d: got gnt=%b we=%b want 0 0", h, wr_gnt, mem_we);
        end
      end
      if (h == 763) begin
        vectors++;
        if (wr_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(100) || mem_wdata !== 12'hABC) begin
          miscompares++;
          $display("FAIL wr_after_fetch: got gnt=%b we=%b addr=%0d data=%h want 1 1 100 abc", wr_gnt, mem_we, mem_addr, mem_wdata);
        end
      end
      if (h == 764) begin
        vectors++;
        if (wr_gnt !== 1'b0 || mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL wr_single_pulse: got gnt=%b we=%b want 0 0", wr_gnt, mem_we);
        end
      end
    end
  endtask

  task automatic test_vmax_wrap();
    logic [PIX_W-1:0] exp;
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, int'(VMAX), 1'b0, 1'b0);
      if (h >= 601 && h <= 760) begin
        vectors++;
        if (mem_addr !== ADDR_W'(h - 601) || mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL row0_fetch_addr h=%0d: got addr=%0d we=%b want addr=%0d we=0", h, mem_addr, mem_we, h - 601);
        end
      end
    end
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, 0, 1'b0, 1'b0);
      exp = (h >= 1 && h <= 640) ? row0_exp[(h - 1) / 4] : '0;
      vectors++;
      if (pix_data !== exp) begin
        miscompares++;
        $display("FAIL row0_pix h=%0d: got %h want %h", h, pix_data, exp);
      end
    end
  endtask

  task automatic test_write_dropped();
    wr_addr = ADDR_W'(19200);
    wr_data = 12'h123;
    cyc(100, 1, 1'b0, 1'b0);
    cyc(101, 1, 1'b1, 1'b0);
    cyc(102, 1, 1'b1, 1'b0);
    vectors++;
    if (wr_gnt !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_oob_drop: got gnt=%b we=%b want 1 0", wr_gnt, mem_we);
    end
    cyc(103, 1, 1'b0, 1'b0);
    wr_addr = ADDR_W'(19199);
    wr_data = 12'h456;
    cyc(104, 1, 1'b1, 1'b0);
    cyc(105, 1, 1'b1, 1'b0);
    vectors++;
    if (wr_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(19199) || mem_wdata !== 12'h456) begin
      miscompares++;
      $display("FAIL wr_last_addr: got gnt=%b we=%b addr=%0d data=%h want 1 1 19199 456", wr_gnt, mem_we, mem_addr, mem_wdata);
    end
    cyc(106, 1, 1'b0, 1'b0);
    wr_addr = ADDR_W'(5);
    wr_data = 12'h007;
    cyc(107, 1, 1'b1, 1'b0);
    cyc(108, 1, 1'b1, 1'b0);
    vectors++; if (wr_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_rate_first: got %b want 1", wr_gnt); end
    cyc(109, 1, 1'b1, 1'b0);
    vectors++; if (wr_gnt !== 1'b0) begin miscompares++; $display("FAIL wr_rate_gap: got %b want 0", wr_gnt); end
    cyc(110, 1, 1'b0, 1'b0);
    vectors++; if (wr_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_rate_second: got %b want 1", wr_gnt); end
    cyc(111, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, 3, 1'b0, (h == 650));
      if (h >= 651) begin
        vectors++;
        if (mem_addr !== '0 || mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_no_reads h=%0d: got addr=%0d we=%b want 0 0", h, mem_addr, mem_we);
        end
      end
      if (h == 800) begin
        vectors++;
        if (fetch_err2 !== 1'b0) begin miscompares++; $display("FAIL deadline_early: got %b want 0", fetch_err2); end
      end
    end
    for (int h = 0; h <= int'(HMAX); h++) begin
      cyc(h, 4, 1'b0, 1'b0);
      if (h == 0) begin
        vectors++;
        if (fetch_err2 !== 1'b1) begin miscompares++; $display("FAIL deadline_err: got %b want 1", fetch_err2); end
        vectors++;
        if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL abort_no_err: got %b want 0", fetch_err); end
      end
      vectors++;
      if (pix_data !== '0 || pix_data2 !== '0) begin
        miscompares++;
        $display("FAIL invalid_bank_pix h=%0d: got %h/%h want 0/0", h, pix_data, pix_data2);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    hcounter = '0;
    vcounter = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    for (int i = 0; i < int'(FB_W * FB_H); i++) fbmem[i] = '0;
    for (int c = 0; c < int'(FB_W); c++) begin
      fbmem[c]            = 12'h800 | PIX_W'(c);
      fbmem[FB_W + c]     = PIX_W'(c);
      fbmem[2 * FB_W + c] = 12'h400 | PIX_W'(c);
      row0_exp[c]         = 12'h800 | PIX_W'(c);
    end
    row0_exp[100] = 12'hABC;

    test_reset();
    test_row_fetch();
    test_pixel_stream();
    test_write_during_fetch();
    test_vmax_wrap();
    test_write_dropped();
    test_reset_mid_fetch();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Owns the single-port framebuffer BRAM port (FB_W x FB_H, PIX_W bits per pixel).
- Time-shares that port between two users:
  - the display fetch engine, which is high priority and deadline-bound;
  - the game-logic writer, which is low priority and uses a req/gnt handshake.
- Prefetches each upscaled framebuffer row into a ping-pong line buffer, then streams pixels aligned with the 640x480@60 timing generator's registered blank.
- Sits between the timing generator, the game logic and the framebuffer BRAM.

Parameters:
- HMAX, 800, last hcounter value (line = HMAX+1 cycles)
- VMAX, 525, last vcounter value
- HLINES, 640, visible columns
- VLINES, 480, visible lines
- FB_W, 160, framebuffer columns
- FB_H, 120, framebuffer rows
- SCALE, 4, display pixels per FB pixel, both axes (power of 2)
- PIX_W, 12, pixel width (RGB444)
- ADDR_W, 15, framebuffer address width
- FETCH_START, 600, hcounter value that triggers a row fetch

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- hcounter  in  11  horizontal position from timing generator
- vcounter  in  11  vertical position from timing generator
- wr_req  in  1  writer request
- wr_addr  in  ADDR_W  writer address (row*FB_W+col)
- wr_data  in  PIX_W  writer data
- wr_gnt  out  1  one-cycle write-commit pulse
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  PIX_W  BRAM write data
- mem_rdata  in  PIX_W  BRAM read data; 1-cycle latency after mem_addr
- pix_data  out  PIX_W  display pixel; 0 when blanked
- fetch_err  out  1  sticky: a row fetch missed its deadline

Behaviour:
- Reset:
  - wr_gnt, mem_we, mem_addr, mem_wdata, pix_data and fetch_err = 0.
  - FSM = IDLE, active bank = 0, bank_valid = 0, col counter = 0.
  - Reset mid-fetch aborts the fetch; no further mem reads are issued.
- Next line: nv = (vcounter==VMAX) ? 0 : vcounter+1.
- Fetch trigger: in the cycle where hcounter==FETCH_START, if nv<VLINES and nv%SCALE==0, then row = nv/SCALE.
- FSM:
  - IDLE -> FETCH on trigger.
  - FETCH issues registered reads, one per cycle: mem_addr = row*FB_W + c for c = 0..FB_W-1, mem_we = 0.
  - Each mem_rdata is written to inactive_bank[c] one cycle after its address is issued.
  - FETCH -> DONE once the last datum is written.
  - DONE -> IDLE at hcounter==HMAX. In that cycle, swap the active bank and set bank_valid = 1.
- Deadline: if a fetch is pending and the FSM is not DONE at hcounter==HMAX:
  - set fetch_err (cleared only by rst);
  - abort the fetch;
  - do not swap banks.
- Writer arbitration:
  - A write is eligible when FSM != FETCH, no trigger is occurring this cycle, wr_req=1 and wr_gnt=0.
  - An eligible write registers mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data and wr_gnt=1, all for exactly one cycle.
  - The writer holds addr/data stable until gnt. Maximum write rate is one write per 2 cycles.
  - If a trigger and a request occur in the same cycle, the trigger wins.
  - A write with wr_addr >= FB_W*FB_H is granted but mem_we stays 0 (dropped).
- Pixel output, registered with 1-cycle latency so it aligns with the generator's registered blank:
  - pix_data = active_bank[hcounter/SCALE] if hcounter<HLINES, vcounter<VLINES and bank_valid;
  - otherwise pix_data = 0.
- Row reuse: a bank is displayed for SCALE consecutive lines. Swaps happen only after completed fetches.
- Line buffer: 2 x FB_W x PIX_W, distributed RAM, one write port (fetch) and one read port (display).

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants HMAX, VMAX, HLINES, VLINES;
  - FB_W, FB_H, SCALE, PIX_W, ADDR_W;
  - the fetch FSM state enum {IDLE, FETCH, DONE}.
- One natural sub-module, vga_line_buffer: the ping-pong 2-bank RAM with a bank-select input, write port and read port.

Test Plan:
- Reset then run a line with vcounter=3, hcounter sweeping:
  - at hcounter=601..760, mem_addr = 160..319 with mem_we=0;
  - fetch_err stays 0;
  - bank swaps at hcounter=800.
- Preload row 1 col c = c, then run line vcounter=4 -> pix_data = c at hcounter 4c..4c+3 (one cycle late); pix_data = 0 at hcounter >= 640.
- Hold wr_req=1, wr_addr=100, wr_data=12'hABC at hcounter=600 on a fetch line:
  - no wr_gnt during the fetch;
  - wr_gnt=1 with mem_we=1 and mem_addr=100 in the cycle after the fetch completes.
- vcounter=VMAX, hcounter=FETCH_START -> row 0 fetch (addresses 0..159); pix at vcounter=0 comes from row 0.
- Write with wr_addr=19200 -> wr_gnt pulses, mem_we stays 0.
- Assert rst at hcounter=650 mid-fetch:
  - mem_addr and mem_we are 0 next cycle;
  - bank_valid = 0, so pix_data = 0 until the next completed fetch;
  - with FETCH_START forced to 700, fetch_err sets at hcounter=800.
